// File: rtl/gcd_req_ctrl_if.sv
// Stream and engine-side signal bundle for gcd_req_ctrl.
// The master modport is the controller; slave is the host/engine/consumer side.
interface gcd_req_ctrl_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_x;
   logic [WIDTH-1:0] in_y;
   logic [WIDTH-1:0] eng_x;
   logic [WIDTH-1:0] eng_y;
   logic             eng_start;
   logic             eng_ack;
   logic             eng_done;
   logic [WIDTH-1:0] eng_gcd;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_gcd;
   logic             out_zero;
   logic             out_timeout;
   logic [15:0]      cnt_ok;
   logic [7:0]       cnt_to;

   modport master (
      input  in_valid, in_x, in_y, eng_done, eng_gcd, out_ready,
      output in_ready, eng_x, eng_y, eng_start, eng_ack,
             out_valid, out_gcd, out_zero, out_timeout, cnt_ok, cnt_to
   );

   modport slave (
      output in_valid, in_x, in_y, eng_done, eng_gcd, out_ready,
      input  in_ready, eng_x, eng_y, eng_start, eng_ack,
             out_valid, out_gcd, out_zero, out_timeout, cnt_ok, cnt_to
   );
endinterface

// File: rtl/gcd_req_ctrl.sv
// Initiator-side controller for the subtractive GCD engine: issues operand pairs,
// resolves zero operands locally, guards each run with a timeout, returns results.
module gcd_req_ctrl #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 1024
) (
   input logic            clk,
   input logic            reset,
   gcd_req_ctrl_if.master bus
);
   localparam int unsigned     TW    = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT - 1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, RESULT} state_t;

   state_t        state;
   logic [TW-1:0] timer;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state           <= IDLE;
         timer           <= '0;
         bus.in_ready    <= 1'b1;
         bus.eng_x       <= '0;
         bus.eng_y       <= '0;
         bus.eng_start   <= 1'b0;
         bus.eng_ack     <= 1'b0;
         bus.out_valid   <= 1'b0;
         bus.out_gcd     <= '0;
         bus.out_zero    <= 1'b0;
         bus.out_timeout <= 1'b0;
         bus.cnt_ok      <= '0;
         bus.cnt_to      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  bus.eng_x    <= bus.in_x;
                  bus.eng_y    <= bus.in_y;
                  bus.in_ready <= 1'b0;
                  // The engine never terminates on a zero operand, so answer here.
                  if (bus.in_x == ZERO || bus.in_y == ZERO) begin
                     bus.out_gcd   <= bus.in_x | bus.in_y;
                     bus.out_zero  <= (bus.in_x == ZERO) && (bus.in_y == ZERO);
                     bus.out_valid <= 1'b1;
                     state         <= RESULT;
                  end else begin
                     bus.eng_start <= 1'b1;
                     state         <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               bus.eng_start <= 1'b0;
               timer         <= '0;
               state         <= WAIT;
            end
            WAIT: begin
               timer <= timer + 1'b1;
               if (bus.eng_done) begin
                  bus.out_gcd <= bus.eng_gcd;
                  bus.eng_ack <= 1'b1;
                  state       <= ACK;
               end else if (timer == TLAST) begin
                  bus.out_gcd     <= '0;
                  bus.out_timeout <= 1'b1;
                  bus.eng_ack     <= 1'b1;
                  state           <= ACK;
               end
            end
            ACK: begin
               bus.eng_ack   <= 1'b0;
               bus.out_valid <= 1'b1;
               state         <= RESULT;
            end
            RESULT: begin
               if (bus.out_ready) begin
                  if (bus.out_timeout) begin
                     if (bus.cnt_to != 8'hFF) bus.cnt_to <= bus.cnt_to + 1'b1;
                  end else begin
                     if (bus.cnt_ok != 16'hFFFF) bus.cnt_ok <= bus.cnt_ok + 1'b1;
                  end
                  bus.out_valid   <= 1'b0;
                  bus.out_zero    <= 1'b0;
                  bus.out_timeout <= 1'b0;
                  bus.in_ready    <= 1'b1;
                  state           <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gcd_req_ctrl.sv
// Self-checking bench for gcd_req_ctrl: directed table, hand sequences, randomized runs
// against a reference model, with a behavioural engine stub of configurable latency.
module tb_gcd_req_ctrl;
   localparam int unsigned TO = 16;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   gcd_req_ctrl_if #(.WIDTH(32)) bus ();

   gcd_req_ctrl #(.WIDTH(32), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int unsigned exp_ok = 0;
   int unsigned exp_to = 0;

   function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Engine stub: done rises eng_lat WAIT cycles after start, held until ack.
   int unsigned eng_lat = 0;
   logic        busy;
   int unsigned scnt;
   logic [31:0] sres;
   always @(posedge clk) begin
      if (!reset) begin
         busy <= 1'b0; scnt <= 0; sres <= '0;
      end else if (bus.eng_start) begin
         busy <= 1'b1; scnt <= 0; sres <= ref_gcd(bus.eng_x, bus.eng_y);
      end else if (bus.eng_ack) begin
         busy <= 1'b0;
      end else if (busy) begin
         scnt <= scnt + 1;
      end
   end
   assign bus.eng_done = busy && (scnt >= eng_lat);
   assign bus.eng_gcd  = bus.eng_done ? sres : 32'hDEADBEEF;

   int unsigned n_start = 0;
   int unsigned n_ack   = 0;
   always @(negedge clk) begin
      if (bus.eng_start) n_start++;
      if (bus.eng_ack)   n_ack++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model(input logic [31:0] x, input logic [31:0] y, input int unsigned lat,
                        output logic [31:0] g, output logic z, output logic t);
      if (x == 0 || y == 0) begin
         g = x | y; z = (x == 0 && y == 0); t = 1'b0;
      end else if (lat < TO) begin
         g = ref_gcd(x, y); z = 1'b0; t = 1'b0;
      end else begin
         g = '0; z = 1'b0; t = 1'b1;
      end
   endtask

   task automatic txn(input logic [31:0] x, input logic [31:0] y, input int unsigned lat,
                      input int unsigned hold, input logic [31:0] eg, input logic ez,
                      input logic et);
      int unsigned waitc, s0, a0, exp_lat;
      logic [31:0] held;
      logic zpath;
      zpath   = (x == 0 || y == 0);
      exp_lat = zpath ? 0 : (lat < TO ? lat + 3 : TO + 2);
      eng_lat = lat;
      @(negedge clk);
      waitc = 0;
      while (!bus.in_ready && waitc < 50) begin @(negedge clk); waitc++; end
      chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
      s0 = n_start; a0 = n_ack;
      bus.in_valid = 1'b1; bus.in_x = x; bus.in_y = y; bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
      waitc = 0;
      while (!bus.out_valid && waitc < 100) begin @(negedge clk); waitc++; end
      chk("out_valid_seen", 32'(bus.out_valid), 32'd1);
      chk("latency", waitc, exp_lat);
      held = bus.out_gcd;
      for (int unsigned i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_gcd", bus.out_gcd, held);
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      chk("out_gcd", bus.out_gcd, eg);
      chk("out_zero", 32'(bus.out_zero), 32'(ez));
      chk("out_timeout", 32'(bus.out_timeout), 32'(et));
      chk("starts", n_start - s0, zpath ? 0 : 1);
      chk("acks", n_ack - a0, zpath ? 0 : 1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      if (et) begin if (exp_to < 255) exp_to++; end
      else    begin if (exp_ok < 65535) exp_ok++; end
      chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
      chk("cnt_ok", 32'(bus.cnt_ok), exp_ok);
      chk("cnt_to", 32'(bus.cnt_to), exp_to);
   endtask

   typedef struct {
      logic [31:0] x, y;
      int unsigned lat, hold;
      logic [31:0] g;
      logic        z, t;
   } vec_t;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      vec_t tbl[9];
      logic [31:0] x, y, eg;
      logic ez, et;
      int unsigned lat, hold, a0;

      tbl[0] = '{32'd48,  32'd18, 3,  0, 32'd6,  1'b0, 1'b0};
      tbl[1] = '{32'd0,   32'd7,  0,  0, 32'd7,  1'b0, 1'b0};
      tbl[2] = '{32'd0,   32'd0,  0,  0, 32'd0,  1'b1, 1'b0};
      tbl[3] = '{32'd9,   32'd0,  0,  2, 32'd9,  1'b0, 1'b0};
      tbl[4] = '{32'd13,  32'd17, 40, 0, 32'd0,  1'b0, 1'b1};
      tbl[5] = '{32'd100, 32'd75, 15, 0, 32'd25, 1'b0, 1'b0};
      tbl[6] = '{32'd35,  32'd14, 2,  5, 32'd7,  1'b0, 1'b0};
      tbl[7] = '{32'd1,   32'd1,  0,  1, 32'd1,  1'b0, 1'b0};
      tbl[8] = '{32'd20,  32'd30, 16, 0, 32'd0,  1'b0, 1'b1};

      bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.out_ready = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_eng_start", 32'(bus.eng_start), 32'd0);
      chk("rst_eng_ack", 32'(bus.eng_ack), 32'd0);
      chk("rst_out_gcd", bus.out_gcd, 32'd0);
      chk("rst_cnt_ok", 32'(bus.cnt_ok), 32'd0);
      chk("rst_cnt_to", 32'(bus.cnt_to), 32'd0);

      foreach (tbl[i]) txn(tbl[i].x, tbl[i].y, tbl[i].lat, tbl[i].hold, tbl[i].g, tbl[i].z, tbl[i].t);

      for (int unsigned n = 0; n < 40; n++) begin
         eg   = 32'($urandom_range(1, 60));
         x    = ($urandom_range(0, 5) == 0) ? 32'd0 : eg * 32'($urandom_range(1, 500));
         y    = ($urandom_range(0, 5) == 0) ? 32'd0 : eg * 32'($urandom_range(1, 500));
         lat  = $urandom_range(0, 20);
         hold = $urandom_range(0, 3);
         model(x, y, lat, eg, ez, et);
         txn(x, y, lat, hold, eg, ez, et);
      end

      // Drive cnt_to into saturation.
      while (exp_to < 255) txn(32'd21, 32'd6, 30, 0, 32'd0, 1'b0, 1'b1);
      txn(32'd21, 32'd6, 30, 0, 32'd0, 1'b0, 1'b1);

      // Reset while the controller sits in WAIT.
      eng_lat = 40;
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_x = 32'd9; bus.in_y = 32'd6;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (5) @(negedge clk);
      a0 = n_ack;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
      chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_eng_x", bus.eng_x, 32'd0);
      chk("mid_out_timeout", 32'(bus.out_timeout), 32'd0);
      chk("mid_cnt_ok", 32'(bus.cnt_ok), 32'd0);
      chk("mid_cnt_to", 32'(bus.cnt_to), 32'd0);
      repeat (3) @(negedge clk);
      chk("mid_no_ack", n_ack - a0, 32'd0);
      exp_ok = 0; exp_to = 0;
      txn(32'd12, 32'd8, 4, 0, 32'd4, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
